// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: widths, the 16-byte state type
// and the ShiftRows / InvShiftRows byte index tables.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;

    // Packed with index 0 leftmost, so byte 0 is the MSB byte of the block.
    typedef logic [0:15][AES_BYTE_W-1:0] aes_state_t;

    typedef logic [3:0] aes_idx_t;

    // Output byte k takes input byte TABLE[k].
    localparam aes_idx_t SR_FWD_IDX [16] = '{
        4'd0,  4'd5,  4'd10, 4'd15,
        4'd4,  4'd9,  4'd14, 4'd3,
        4'd8,  4'd13, 4'd2,  4'd7,
        4'd12, 4'd1,  4'd6,  4'd11
    };

    localparam aes_idx_t SR_INV_IDX [16] = '{
        4'd0,  4'd13, 4'd10, 4'd7,
        4'd4,  4'd1,  4'd14, 4'd11,
        4'd8,  4'd5,  4'd2,  4'd15,
        4'd12, 4'd9,  4'd6,  4'd3
    };

endpackage

// File: rtl/shift_rows_if.sv
// Handshake bundle for the ShiftRows stage.
// slave: stage view (input side + output side); master: the driving environment.
interface shift_rows_if;
    import aes_pkg::*;

    logic                   valid_i;
    logic                   ready_o;
    logic                   inverse_i;
    logic [AES_BLOCK_W-1:0] block;
    logic [AES_BLOCK_W-1:0] shifted_block;
    logic                   valid_o;
    logic                   ready_i;

    modport slave (
        input  valid_i,
        input  inverse_i,
        input  block,
        input  ready_i,
        output ready_o,
        output shifted_block,
        output valid_o
    );

    modport master (
        output valid_i,
        output inverse_i,
        output block,
        output ready_i,
        input  ready_o,
        input  shifted_block,
        input  valid_o
    );

endinterface

// File: rtl/shift_rows_core.sv
// Combinational ShiftRows / InvShiftRows byte permutation.
// Ports: block (128b in), inverse (1 = InvShiftRows), result (128b out).
module shift_rows_core
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] block,
    input  logic                   inverse,
    output logic [AES_BLOCK_W-1:0] result
);

    aes_state_t in_s;
    aes_state_t res_s;

    always_comb begin
        in_s  = aes_state_t'(block);
        res_s = '0;
        for (int k = 0; k < 16; k++) begin
            if (inverse) begin
                res_s[k] = in_s[SR_INV_IDX[k]];
            end else begin
                res_s[k] = in_s[SR_FWD_IDX[k]];
            end
        end
    end

    assign result = AES_BLOCK_W'(res_s);

endmodule

// File: rtl/shift_rows.sv
// Registered ShiftRows stage with valid/ready handshake (1-cycle latency).
// Ports: clk_i, reset_i (sync, active-high), bus (shift_rows_if.slave).
module shift_rows
    import aes_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_i,
    shift_rows_if.slave  bus
);

    logic                   valid_q;
    logic                   valid_d;
    logic [AES_BLOCK_W-1:0] data_q;
    logic [AES_BLOCK_W-1:0] data_d;
    logic [AES_BLOCK_W-1:0] perm;
    logic                   accept;

    shift_rows_core u_core (
        .block   (bus.block),
        .inverse (bus.inverse_i),
        .result  (perm)
    );

    // Single register, no skid: free when empty or being drained.
    // Reset term keeps ready high while the register is being cleared.
    assign bus.ready_o = ~valid_q | bus.ready_i | reset_i;

    assign accept = bus.valid_i & ~valid_q
                  | bus.valid_i & bus.ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = perm;
        end else if (bus.ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.valid_o       = valid_q;
    assign bus.shifted_block = data_q;

endmodule

// File: tb/tb_shift_rows.sv
// Directed self-checking bench for the shift_rows stage.
// Each task drives one scenario and checks its own results.
module tb_shift_rows;

    logic clk;
    logic reset_i;
    int   n_run;
    int   n_fail;

    shift_rows_if bus ();

    shift_rows dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference permutation from the row/column definition.
    function automatic logic [127:0] model(input logic [127:0] b,
                                           input logic inv);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv) src = (c - r + 4) % 4;
                else     src = (c + r) % 4;
                o[127-8*(r+4*c) -: 8] = b[127-8*(r+4*src) -: 8];
            end
        end
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i       = 1'b1;
        bus.valid_i   = 1'b0;
        bus.inverse_i = 1'b0;
        bus.block     = '0;
        bus.ready_i   = 1'b0;
        step();
        step();
        n_run++;
        if (bus.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b want 0", bus.valid_o);
        end
        n_run++;
        if (bus.shifted_block !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0", bus.shifted_block);
        end
        n_run++;
        if (bus.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 1", bus.ready_o);
        end
        reset_i = 1'b0;
        step();
    endtask

    task automatic send_one(input logic [127:0] b, input logic inv,
                            input logic [127:0] exp, input string nm);
        bus.block     = b;
        bus.inverse_i = inv;
        bus.valid_i   = 1'b1;
        bus.ready_i   = 1'b1;
        #1;
        n_run++;
        if (bus.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready got %b want 1", nm, bus.ready_o);
        end
        step();
        bus.valid_i = 1'b0;
        n_run++;
        if (bus.valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid got %b want 1", nm, bus.valid_o);
        end
        n_run++;
        if (bus.shifted_block !== exp) begin
            n_fail++;
            $display("FAIL %s_data got %h want %h", nm,
                     bus.shifted_block, exp);
        end
        step();
        n_run++;
        if (bus.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain got %b want 0", nm, bus.valid_o);
        end
    endtask

    task automatic test_forward();
        send_one(128'h63cab7040953d051cd60e0e7ba70e18c, 1'b0,
                 128'h6353e08c0960e104cd70b751bacad0e7, "fwd_fips");
    endtask

    task automatic test_inverse();
        send_one(128'h6353e08c0960e104cd70b751bacad0e7, 1'b1,
                 128'h63cab7040953d051cd60e0e7ba70e18c, "inv_fips");
    endtask

    task automatic test_index();
        send_one(128'h000102030405060708090a0b0c0d0e0f, 1'b0,
                 128'h00050a0f04090e03080d02070c01060b, "fwd_index");
        send_one(128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                 128'h000d0a0704010e0b0805020f0c090603, "inv_index");
    endtask

    task automatic test_roundtrip();
        logic [127:0] orig;
        logic [127:0] mid;
        for (int i = 0; i < 4; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            bus.block     = orig;
            bus.inverse_i = 1'b0;
            bus.valid_i   = 1'b1;
            bus.ready_i   = 1'b1;
            step();
            mid = bus.shifted_block;
            n_run++;
            if (mid !== model(orig, 1'b0)) begin
                n_fail++;
                $display("FAIL rt_fwd[%0d] got %h want %h", i,
                         mid, model(orig, 1'b0));
            end
            bus.block     = mid;
            bus.inverse_i = 1'b1;
            step();
            n_run++;
            if (bus.shifted_block !== orig) begin
                n_fail++;
                $display("FAIL rt_inv[%0d] got %h want %h", i,
                         bus.shifted_block, orig);
            end
        end
        bus.valid_i = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic [127:0] a;
        logic [127:0] ea;
        a  = 128'h00112233445566778899aabbccddeeff;
        ea = 128'h0055aaff4499ee3388dd2277cc1166bb;
        bus.block     = a;
        bus.inverse_i = 1'b0;
        bus.valid_i   = 1'b1;
        bus.ready_i   = 1'b0;
        step();
        bus.block = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        #1;
        n_run++;
        if (bus.ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready got %b want 0", bus.ready_o);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_run++;
            if (bus.valid_o !== 1'b1 || bus.shifted_block !== ea) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got %b/%h want 1/%h", i,
                         bus.valid_o, bus.shifted_block, ea);
            end
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        step();
        n_run++;
        if (bus.valid_o !== 1'b0 || bus.shifted_block !== ea) begin
            n_fail++;
            $display("FAIL bp_release got %b/%h want 0/%h",
                     bus.valid_o, bus.shifted_block, ea);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] blk [8];
        for (int i = 0; i < 8; i++) begin
            blk[i] = 128'h000102030405060708090a0b0c0d0e0f
                   + {16{8'(i * 17)}};
        end
        bus.ready_i   = 1'b1;
        bus.inverse_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.block   = blk[i];
            bus.valid_i = 1'b1;
            step();
            n_run++;
            if (bus.valid_o !== 1'b1 ||
                bus.shifted_block !== model(blk[i], 1'b0)) begin
                n_fail++;
                $display("FAIL stream[%0d] got %b/%h want 1/%h", i,
                         bus.valid_o, bus.shifted_block,
                         model(blk[i], 1'b0));
            end
        end
        bus.valid_i = 1'b0;
        step();
        n_run++;
        if (bus.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end got %b want 0", bus.valid_o);
        end
    endtask

    task automatic test_reset_mid();
        bus.block     = 128'h63cab7040953d051cd60e0e7ba70e18c;
        bus.inverse_i = 1'b0;
        bus.valid_i   = 1'b1;
        bus.ready_i   = 1'b0;
        step();
        bus.valid_i = 1'b0;
        n_run++;
        if (bus.valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_pre got %b want 1", bus.valid_o);
        end
        reset_i = 1'b1;
        #1;
        n_run++;
        if (bus.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_ready_in_reset got %b want 1", bus.ready_o);
        end
        step();
        n_run++;
        if (bus.valid_o !== 1'b0 || bus.shifted_block !== 128'h0) begin
            n_fail++;
            $display("FAIL rm_clear got %b/%h want 0/0",
                     bus.valid_o, bus.shifted_block);
        end
        reset_i = 1'b0;
        #1;
        n_run++;
        if (bus.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_ready_after got %b want 1", bus.ready_o);
        end
        step();
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        test_reset();
        test_forward();
        test_inverse();
        test_index();
        test_roundtrip();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
